// File: rtl/perf_mmio_types.sv
// Shared types for the performance-counter MMIO block.
// Holds the register offsets within the 256-byte window and the bus FSM state type.
package perf_mmio_types;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [7:0] OFS_CTRL     = 8'h00;
  localparam logic [7:0] OFS_CYCLE_LO = 8'h04;
  localparam logic [7:0] OFS_CYCLE_HI = 8'h08;
  localparam logic [7:0] OFS_OVF      = 8'h0C;
  localparam logic [7:0] OFS_EVT0     = 8'h10;

endpackage

// File: rtl/perf_event_counter.sv
// One 32-bit event counter.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : counting enabled
//   inc          : event this cycle
//   clr          : synchronous zero, takes priority over inc
//   count[31:0]  : current count
//   wrap         : high for the cycle in which count rolls from all-ones to zero
module perf_event_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] count,
  output logic        wrap
);

  // Combinational so the parent can set its sticky flag on the same edge as the rollover.
  assign wrap = en && inc && !clr && (&count);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && inc) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/perf_cnt_mmio.sv
// Memory-mapped performance counter block: a 64-bit cycle counter, NUM_EVT event
// counters with sticky overflow flags, and a two-cycle request/response bus.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   mem_read, mem_write : requests, held until mem_resp
//   mem_address         : byte address, [1:0] ignored
//   mem_wdata           : write data
//   mem_byte_enable     : write byte lanes
//   mem_rdata           : read data, valid while mem_resp
//   mem_resp            : one-cycle completion pulse
//   evt                 : per-cycle event pulses, bit i feeds counter i
//
// FSM states:
//   state   | meaning
//   ST_IDLE | waiting for a request; access performed on the leaving edge
//   ST_RESP | mem_resp high, mem_rdata held; always returns to ST_IDLE
module perf_cnt_mmio
  import perf_mmio_types::*;
#(
  parameter int          NUM_EVT   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_address,
  input  logic [31:0]        mem_wdata,
  input  logic [3:0]         mem_byte_enable,
  output logic [31:0]        mem_rdata,
  output logic               mem_resp,
  input  logic [NUM_EVT-1:0] evt
);

  state_t             state;
  logic               enable;
  logic [63:0]        cycle;
  logic [31:0]        cycle_hi_shadow;
  logic [NUM_EVT-1:0] ovf;
  logic [31:0]        evt_count [NUM_EVT];
  logic [NUM_EVT-1:0] evt_wrap;
  logic [NUM_EVT-1:0] ovf_w1c;

  logic        access;
  logic        in_window;
  logic        do_write;
  logic        do_read;
  logic        ctrl_wr;
  logic        clear;
  logic        ovf_wr;
  logic [7:0]  offset;
  logic [31:0] read_data;

  // Address bits [1:0] and write-data bits beyond the flag width carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{mem_address[1:0], mem_wdata};

  assign in_window = (mem_address[31:8] == BASE_ADDR[31:8]);
  assign offset    = {mem_address[7:2], 2'b00};
  assign access    = (state == ST_IDLE) && (mem_read || mem_write);
  // A simultaneous read+write is treated purely as a write.
  assign do_write  = access && mem_write && in_window;
  assign do_read   = access && mem_read && !mem_write && in_window;
  assign ctrl_wr   = do_write && (offset == OFS_CTRL) && mem_byte_enable[0];
  assign clear     = ctrl_wr && mem_wdata[1];
  assign ovf_wr    = do_write && (offset == OFS_OVF);

  always_comb begin
    ovf_w1c = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      ovf_w1c[i] = ovf_wr && mem_wdata[i] && mem_byte_enable[i / 8];
    end
  end

  always_comb begin
    read_data = '0;
    if (in_window) begin
      case (offset)
        OFS_CTRL:     read_data[0] = enable;
        OFS_CYCLE_LO: read_data = cycle[31:0];
        OFS_CYCLE_HI: read_data = cycle_hi_shadow;
        OFS_OVF:      read_data[NUM_EVT-1:0] = ovf;
        default: begin
          for (int i = 0; i < NUM_EVT; i++) begin
            if (offset == OFS_EVT0 + 8'(4 * i)) read_data = evt_count[i];
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
    perf_event_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (enable),
      .inc   (evt[g]),
      .clr   (clear),
      .count (evt_count[g]),
      .wrap  (evt_wrap[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      mem_resp        <= 1'b0;
      mem_rdata       <= '0;
      enable          <= 1'b1;
      cycle           <= '0;
      cycle_hi_shadow <= '0;
      ovf             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_read || mem_write) begin
            state     <= ST_RESP;
            mem_resp  <= 1'b1;
            mem_rdata <= do_read ? read_data : '0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          mem_resp  <= 1'b0;
          mem_rdata <= '0;
        end
      endcase

      if (clear) begin
        cycle           <= '0;
        cycle_hi_shadow <= '0;
        ovf             <= '0;
      end else begin
        if (enable) cycle <= cycle + 64'd1;
        if (do_read && (offset == OFS_CYCLE_LO)) cycle_hi_shadow <= cycle[63:32];
        // A wrap on the same edge as a write-1-to-clear leaves the flag set.
        ovf <= (ovf & ~ovf_w1c) | evt_wrap;
      end

      if (ctrl_wr) enable <= mem_wdata[0];
    end
  end

endmodule

// File: tb/tb_perf_cnt_mmio.sv
module tb_perf_cnt_mmio;

  localparam int          NUM_EVT = 8;
  localparam logic [31:0] BASE    = 32'hFFFF_FF00;

  logic               clk = 1'b0;
  logic               rst;
  logic               mem_read;
  logic               mem_write;
  logic [31:0]        mem_address;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_byte_enable;
  logic [31:0]        mem_rdata;
  logic               mem_resp;
  logic [NUM_EVT-1:0] evt;

  always #5 clk = ~clk;

  perf_cnt_mmio #(.NUM_EVT(NUM_EVT), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .evt             (evt)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Reference model state, expressed as plain counters.
  bit          m_en;
  logic [63:0] m_cyc;
  logic [31:0] m_ev [NUM_EVT];
  logic [31:0] m_shadow;
  logic [31:0] m_ovf;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_en = 1'b1;
    m_cyc = '0;
    m_shadow = '0;
    m_ovf = '0;
    for (int i = 0; i < NUM_EVT; i++) m_ev[i] = '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    int off;
    int idx;
    if (addr[31:8] != BASE[31:8]) return '0;
    off = int'(addr[7:0]) & 32'hFC;
    if (off == 0) return {31'b0, m_en};
    if (off == 4) return m_cyc[31:0];
    if (off == 8) return m_shadow;
    if (off == 12) return m_ovf;
    idx = (off - 16) / 4;
    if (off >= 16 && idx < NUM_EVT) return m_ev[idx];
    return '0;
  endfunction

  function automatic void model_step(input bit acc, input bit rd, input bit wr,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] be);
    bit hit;
    int off;
    logic [31:0] wraps;
    hit = (addr[31:8] == BASE[31:8]);
    off = int'(addr[7:0]) & 32'hFC;
    wraps = '0;
    if (acc && wr && hit && off == 0 && be[0] && wdata[1]) begin
      model_reset();
      m_en = wdata[0];
      return;
    end
    if (acc && rd && !wr && hit && off == 4) m_shadow = m_cyc[63:32];
    if (m_en) begin
      m_cyc = m_cyc + 64'd1;
      for (int i = 0; i < NUM_EVT; i++) begin
        if (evt[i]) begin
          if (m_ev[i] == 32'hFFFF_FFFF) wraps[i] = 1'b1;
          m_ev[i] = m_ev[i] + 32'd1;
        end
      end
    end
    if (acc && wr && hit && off == 12) begin
      for (int i = 0; i < NUM_EVT; i++) if (wdata[i] && be[i / 8]) m_ovf[i] = 1'b0;
    end
    m_ovf = m_ovf | wraps;
    if (acc && wr && hit && off == 0 && be[0]) m_en = wdata[0];
  endfunction

  task automatic edge_step(input bit acc, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    @(posedge clk);
    model_step(acc, rd, wr, addr, wdata, be);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) edge_step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic bus(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be);
    mem_read = rd;
    mem_write = wr;
    mem_address = addr;
    mem_wdata = wdata;
    mem_byte_enable = be;
    exp_q.push_back(wr ? 32'h0 : model_read(addr));
    edge_step(1'b1, rd, wr, addr, wdata, be);
    check("resp_rise", 32'(mem_resp), 32'h1);
    edge_step(1'b0, rd, wr, addr, wdata, be);
    check("resp_fall", 32'(mem_resp), 32'h0);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic rd32(input logic [31:0] addr);
    bus(1'b1, 1'b0, addr, '0, 4'h0);
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    bus(1'b0, 1'b1, addr, data, 4'hF);
  endtask

  // Monitor: compares read data whenever the DUT signals a response.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mem_resp === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got rdata %h with no pending access at %0t", mem_rdata, $time);
        end else begin
          e = exp_q.pop_front();
          check("rdata", mem_rdata, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    int kind;
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_wdata = '0;
    mem_byte_enable = '0;
    evt = '0;
    #1;
    check("reset_resp", 32'(mem_resp), 32'h0);
    check("reset_rdata", mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    rd32(BASE + 32'h00);

    evt = NUM_EVT'(4);
    tick(10);
    evt = '0;
    for (int i = 0; i < NUM_EVT; i++) rd32(BASE + 32'h10 + 32'(4 * i));

    wr32(BASE + 32'h00, 32'h0);
    for (int k = 0; k < 5; k++) begin
      evt = NUM_EVT'(1);
      tick(1);
      evt = '0;
      tick(1);
    end
    rd32(BASE + 32'h10);
    wr32(BASE + 32'h00, 32'h3);
    for (int i = 0; i < NUM_EVT; i++) rd32(BASE + 32'h10 + 32'(4 * i));
    rd32(BASE + 32'h04);
    rd32(BASE + 32'h08);
    rd32(BASE + 32'h0C);
    rd32(BASE + 32'h00);

    @(negedge clk);
    force dut.g_evt[1].u_cnt.count = 32'hFFFF_FFFE;
    #1 release dut.g_evt[1].u_cnt.count;
    m_ev[1] = 32'hFFFF_FFFE;
    evt = NUM_EVT'(2);
    tick(2);
    evt = '0;
    rd32(BASE + 32'h14);
    rd32(BASE + 32'h0C);
    wr32(BASE + 32'h0C, 32'h2);
    rd32(BASE + 32'h0C);

    @(negedge clk);
    force dut.cycle = 64'h0000_0005_FFFF_FFC0;
    #1 release dut.cycle;
    m_cyc = 64'h0000_0005_FFFF_FFC0;
    rd32(BASE + 32'h04);
    tick(100);
    rd32(BASE + 32'h08);
    rd32(BASE + 32'h04);
    rd32(32'h0000_0010);

    @(negedge clk);
    force dut.g_evt[3].u_cnt.count = 32'hFFFF_FFF0;
    force dut.g_evt[6].u_cnt.count = 32'hFFFF_FFE8;
    #1;
    release dut.g_evt[3].u_cnt.count;
    release dut.g_evt[6].u_cnt.count;
    m_ev[3] = 32'hFFFF_FFF0;
    m_ev[6] = 32'hFFFF_FFE8;

    for (int it = 0; it < 400; it++) begin
      evt = NUM_EVT'($urandom);
      if ($urandom_range(0, 9) < 5) begin
        tick(1);
      end else begin
        kind = int'($urandom_range(0, 6));
        case (kind)
          0, 1: rd32(BASE | 32'($urandom_range(0, 47) << 2) | 32'($urandom_range(0, 3)));
          2: rd32($urandom & 32'h7FFF_FFFF);
          3: begin
            a = $urandom;
            a[1] = ($urandom_range(0, 7) == 0);
            a[0] = ($urandom_range(0, 3) != 0);
            bus(1'b0, 1'b1, BASE, a, 4'($urandom));
          end
          4: bus(1'b0, 1'b1, BASE + 32'h0C, $urandom, 4'($urandom));
          5: bus(1'b0, 1'b1, BASE | 32'($urandom_range(1, 11) << 2), $urandom, 4'hF);
          default: bus(1'b1, 1'b1, BASE | 32'($urandom_range(1, 15) << 2), $urandom, 4'($urandom));
        endcase
      end
    end
    evt = '0;
    rd32(BASE + 32'h0C);
    rd32(BASE + 32'h1C);
    rd32(BASE + 32'h28);

    mem_write = 1'b1;
    mem_address = BASE;
    mem_wdata = 32'h0;
    mem_byte_enable = 4'hF;
    edge_step(1'b1, 1'b0, 1'b1, BASE, 32'h0, 4'hF);
    check("rst_pre_resp", 32'(mem_resp), 32'h1);
    rst = 1'b1;
    #1;
    check("rst_drop_resp", 32'(mem_resp), 32'h0);
    check("rst_drop_rdata", mem_rdata, 32'h0);
    mem_write = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    rd32(BASE + 32'h00);
    tick(2);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
